mdu_sequencer: RTL

//  Iterative multiply/divide unit with its own HI/LO registers. Replaces the single-cycle
//  {hi,lo}=a*b path in the ALU. Control decode issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here.

---
 rtl/mdu_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Runs one radix-2 step per cycle, then applies a sign fix-up cycle before writing HI/LO.
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned AW  = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [AW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_srca;
    logic               r_is_div;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_divzero;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [AW-1:0]      w_mul_next;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [AW-1:0]      w_div_next;
    logic [AW-1:0]      w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic               w_last;

    // Operand magnitudes; sign flags are only meaningful for signed ops (op[0]).
    assign w_sa    = op[0] & srca[WIDTH-1];
    assign w_sb    = op[0] & srcb[WIDTH-1];
    assign w_abs_a = w_sa ? WIDTH'(-srca) : srca;
    assign w_abs_b = w_sb ? WIDTH'(-srcb) : srcb;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : (WIDTH+1)'(0));
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
    assign w_div_ge   = r_acc[AW-1:WIDTH-1] >= {1'b0, r_opb};
    assign w_div_rem  = WIDTH'(r_acc[AW-1:WIDTH-1] - {1'b0, r_opb});
    assign w_div_next = w_div_ge ? {w_div_rem, r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[AW-2:0], 1'b0};

    // Sign fix-up of the finished magnitude result.
    assign w_prod = r_qneg ? AW'(-r_acc) : r_acc;

    always_comb begin
        w_fix_hi = w_prod[AW-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_divzero) begin
                w_fix_hi = r_srca;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_rneg ? WIDTH'(-r_acc[AW-1:WIDTH]) : r_acc[AW-1:WIDTH];
                w_fix_lo = r_qneg ? WIDTH'(-r_acc[WIDTH-1:0])  : r_acc[WIDTH-1:0];
            end
        end
    end

    assign w_last = (r_cnt == CW'(0));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc     <= '0;
            r_opb     <= '0;
            r_srca    <= '0;
            r_is_div  <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_divzero <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                        r_opb     <= op[1] ? w_abs_b : w_abs_a;
                        r_srca    <= srca;
                        r_is_div  <= op[1];
                        r_qneg    <= w_sa ^ w_sb;
                        r_rneg    <= w_sa;
                        r_divzero <= (srcb == '0);
                        r_cnt     <= CW'(WIDTH - 1);
                    end else begin
                        if (mthi) begin
                            r_hi <= srca;
                        end
                        if (mtlo) begin
                            r_lo <= srca;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    if (!w_last) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    if (!w_last) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIXUP: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | rd_hilo | mthi | mtlo);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
